// File: rtl/mbus_glitch_sweep_if.sv
// Link between the sweep sequencer and the glitch injector / test harness.
// The sequencer (master) drives the injector enable, the glitch width and the
// launch strobe. The harness (slave) answers with a pass/fail verdict.
interface mbus_glitch_sweep_if;
  logic        GLITCH_ENABLE;
  logic [31:0] GLITCH_CYCLES;
  logic        TRIAL_GO;
  logic        TRIAL_RESULT_VALID;
  logic        TRIAL_RESULT_FAIL;

  modport master (
    output GLITCH_ENABLE,
    output GLITCH_CYCLES,
    output TRIAL_GO,
    input  TRIAL_RESULT_VALID,
    input  TRIAL_RESULT_FAIL
  );

  modport slave (
    input  GLITCH_ENABLE,
    input  GLITCH_CYCLES,
    input  TRIAL_GO,
    output TRIAL_RESULT_VALID,
    output TRIAL_RESULT_FAIL
  );
endinterface

// File: rtl/mbus_glitch_sweep.sv
// Glitch-width sweep sequencer. Each trial does the following:
//   - holds the injector disabled for IDLE_GAP cycles;
//   - arms it and pulses TRIAL_GO;
//   - waits for a harness verdict or a timeout.
// It also counts failing and timed-out trials. Every output is registered.
module mbus_glitch_sweep #(
  parameter int unsigned IDLE_GAP = 16
) (
  input  logic                SYSCLK,
  input  logic                RESETn,
  input  logic                START,
  input  logic                ABORT,
  input  logic [31:0]         CFG_FIRST,
  input  logic [31:0]         CFG_STEP,
  input  logic [15:0]         CFG_NUM,
  input  logic [23:0]         CFG_TIMEOUT,
  mbus_glitch_sweep_if.master mbus,
  output logic                BUSY,
  output logic                DONE,
  output logic [15:0]         TRIAL_IDX,
  output logic [15:0]         FAIL_COUNT,
  output logic [15:0]         TIMEOUT_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ARM,
    S_WAIT,
    S_NEXT
  } state_t;

  // The gap counter counts down to zero, so a load of IDLE_GAP-1 gives
  // exactly IDLE_GAP cycles in GAP.
  localparam logic [15:0] GAP_LOAD = 16'(IDLE_GAP - 1);

  state_t      state;
  logic [31:0] step_reg;
  logic [15:0] num_reg;
  logic [23:0] timeout_reg;
  logic [15:0] gap_cnt;
  logic [23:0] wait_cnt;

  // Sequencer FSM. State and every output are updated here together.
  always_ff @(posedge SYSCLK) begin
    if (!RESETn) begin
      state              <= S_IDLE;
      step_reg           <= '0;
      num_reg            <= '0;
      timeout_reg        <= '0;
      gap_cnt            <= '0;
      wait_cnt           <= '0;
      mbus.GLITCH_ENABLE <= 1'b0;
      mbus.GLITCH_CYCLES <= '0;
      mbus.TRIAL_GO      <= 1'b0;
      BUSY               <= 1'b0;
      DONE               <= 1'b0;
      TRIAL_IDX          <= '0;
      FAIL_COUNT         <= '0;
      TIMEOUT_COUNT      <= '0;
    end else if (ABORT) begin
      // ABORT beats START and a pending verdict. The statistics and the
      // width stay visible for post-mortem inspection.
      state              <= S_IDLE;
      mbus.GLITCH_ENABLE <= 1'b0;
      mbus.TRIAL_GO      <= 1'b0;
      BUSY               <= 1'b0;
      DONE               <= 1'b0;
    end else begin
      mbus.TRIAL_GO <= 1'b0;
      DONE          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            if (CFG_NUM == 16'd0) begin
              DONE <= 1'b1;
            end else begin
              step_reg           <= CFG_STEP;
              num_reg            <= CFG_NUM;
              timeout_reg        <= CFG_TIMEOUT;
              mbus.GLITCH_CYCLES <= CFG_FIRST;
              TRIAL_IDX          <= '0;
              FAIL_COUNT         <= '0;
              TIMEOUT_COUNT      <= '0;
              gap_cnt            <= GAP_LOAD;
              BUSY               <= 1'b1;
              state              <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 16'd0) begin
            mbus.GLITCH_ENABLE <= 1'b1;
            mbus.TRIAL_GO      <= 1'b1;
            state              <= S_ARM;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        S_ARM: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // If a verdict and the timeout arrive in the same cycle, the
          // verdict is the one that counts.
          if (mbus.TRIAL_RESULT_VALID) begin
            if (mbus.TRIAL_RESULT_FAIL) begin
              FAIL_COUNT <= FAIL_COUNT + 16'd1;
            end
            mbus.GLITCH_ENABLE <= 1'b0;
            state              <= S_NEXT;
          end else if (wait_cnt == timeout_reg) begin
            TIMEOUT_COUNT      <= TIMEOUT_COUNT + 16'd1;
            mbus.GLITCH_ENABLE <= 1'b0;
            state              <= S_NEXT;
          end else begin
            wait_cnt <= wait_cnt + 24'd1;
          end
        end
        S_NEXT: begin
          if (TRIAL_IDX == num_reg - 16'd1) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else begin
            TRIAL_IDX          <= TRIAL_IDX + 16'd1;
            mbus.GLITCH_CYCLES <= mbus.GLITCH_CYCLES + step_reg;
            gap_cnt            <= GAP_LOAD;
            state              <= S_GAP;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_glitch_sweep.sv
// Directed bench for mbus_glitch_sweep. The bench pushes the expected glitch
// widths to a scoreboard queue when it starts a sweep. It pops and compares
// one width at every TRIAL_GO.
module tb_mbus_glitch_sweep;
  localparam int unsigned GAP = 4;

  logic        SYSCLK;
  logic        RESETn;
  logic        START;
  logic        ABORT;
  logic [31:0] CFG_FIRST;
  logic [31:0] CFG_STEP;
  logic [15:0] CFG_NUM;
  logic [23:0] CFG_TIMEOUT;
  logic        BUSY;
  logic        DONE;
  logic [15:0] TRIAL_IDX;
  logic [15:0] FAIL_COUNT;
  logic [15:0] TIMEOUT_COUNT;

  int          total;
  int          bad;
  logic [31:0] exp_q[$];
  int          wlen;
  bit          flag;

  mbus_glitch_sweep_if mbus();

  mbus_glitch_sweep #(.IDLE_GAP(GAP)) dut (
    .SYSCLK        (SYSCLK),
    .RESETn        (RESETn),
    .START         (START),
    .ABORT         (ABORT),
    .CFG_FIRST     (CFG_FIRST),
    .CFG_STEP      (CFG_STEP),
    .CFG_NUM       (CFG_NUM),
    .CFG_TIMEOUT   (CFG_TIMEOUT),
    .mbus          (mbus.master),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .TRIAL_IDX     (TRIAL_IDX),
    .FAIL_COUNT    (FAIL_COUNT),
    .TIMEOUT_COUNT (TIMEOUT_COUNT)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  // Advance one cycle. Afterwards, outputs are stable and inputs may change.
  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_idx"}, 32'(TRIAL_IDX), 32'd0);
    check({tag, "_fail"}, 32'(FAIL_COUNT), 32'd0);
    check({tag, "_tmo"}, 32'(TIMEOUT_COUNT), 32'd0);
    check({tag, "_en"}, 32'(mbus.GLITCH_ENABLE), 32'd0);
    check({tag, "_go"}, 32'(mbus.TRIAL_GO), 32'd0);
    check({tag, "_cyc"}, mbus.GLITCH_CYCLES, 32'd0);
  endtask

  // Pulse START and queue the widths the sweep should present.
  task automatic start_sweep(input logic [31:0] first, input logic [31:0] step,
                             input logic [15:0] num, input logic [23:0] tmo);
    logic [31:0] w;
    CFG_FIRST   = first;
    CFG_STEP    = step;
    CFG_NUM     = num;
    CFG_TIMEOUT = tmo;
    START       = 1'b1;
    tick();
    START = 1'b0;
    w = first;
    for (int i = 0; i < int'(num); i++) begin
      exp_q.push_back(w);
      w = w + step;
    end
    check("start_busy", 32'(BUSY), 32'(num != 16'd0));
  endtask

  // Wait for the next ARM cycle. Check the launch pulse, the enable-low gap
  // and the scoreboard width.
  task automatic wait_go(input int exp_low);
    int low;
    bit seen;
    low  = 1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mbus.GLITCH_ENABLE) begin
        seen = 1;
        break;
      end
      low++;
    end
    check("go_seen", 32'(seen), 32'd1);
    check("trial_go", 32'(mbus.TRIAL_GO), 32'd1);
    check("gap_low", 32'(low), 32'(exp_low));
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) check("glitch_cycles", mbus.GLITCH_CYCLES, exp_q.pop_front());
  endtask

  // Run the harness side of one trial. The mode is 0 for pass, 1 for fail and
  // 2 for no answer. The verdict is sampled on the delay-th edge after ARM.
  // wait_len returns the number of WAIT cycles seen.
  task automatic run_trial(input int delay, input int mode, output int wait_len);
    bit exited;
    exited   = 0;
    wait_len = 0;
    for (int i = 1; i <= 400; i++) begin
      mbus.TRIAL_RESULT_VALID = (mode != 2) && (i == delay);
      mbus.TRIAL_RESULT_FAIL  = (mode == 1);
      tick();
      if (i == 1) check("go_one_cycle", 32'(mbus.TRIAL_GO), 32'd0);
      if (!mbus.GLITCH_ENABLE) begin
        exited = 1;
        break;
      end
      wait_len++;
    end
    mbus.TRIAL_RESULT_VALID = 1'b0;
    mbus.TRIAL_RESULT_FAIL  = 1'b0;
    check("trial_exit", 32'(exited), 32'd1);
    $display("trial idx=%0d width=0x%08h mode=%0d wait=%0d fails=%0d timeouts=%0d",
             TRIAL_IDX, mbus.GLITCH_CYCLES, mode, wait_len, FAIL_COUNT, TIMEOUT_COUNT);
  endtask

  // Called from the NEXT cycle of the last trial.
  task automatic finish_sweep(input logic [15:0] idx, input logic [15:0] f,
                              input logic [15:0] t, input logic [31:0] cyc);
    tick();
    check("done_pulse", 32'(DONE), 32'd1);
    check("busy_fall", 32'(BUSY), 32'd0);
    check("final_idx", 32'(TRIAL_IDX), 32'(idx));
    check("final_fail", 32'(FAIL_COUNT), 32'(f));
    check("final_tmo", 32'(TIMEOUT_COUNT), 32'(t));
    check("final_cyc", mbus.GLITCH_CYCLES, cyc);
    check("final_en", 32'(mbus.GLITCH_ENABLE), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    tick();
    check("done_once", 32'(DONE), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RESETn = 1'b0;
    START  = 1'b0;
    ABORT  = 1'b0;
    CFG_FIRST = '0;
    CFG_STEP = '0;
    CFG_NUM = '0;
    CFG_TIMEOUT = '0;
    mbus.TRIAL_RESULT_VALID = 1'b0;
    mbus.TRIAL_RESULT_FAIL  = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    RESETn = 1'b1;
    tick();

    // Basic sweep: widths 10, 15 and 20, with a pass after each launch.
    start_sweep(32'd10, 32'd5, 16'd3, 24'd100);
    wait_go(GAP);
    run_trial(20, 0, wlen);
    check("basic_wait", 32'(wlen), 32'd19);
    wait_go(GAP + 1);
    run_trial(20, 0, wlen);
    wait_go(GAP + 1);
    run_trial(20, 0, wlen);
    finish_sweep(16'd2, 16'd0, 16'd0, 32'd20);

    // Fail/timeout mix.
    start_sweep(32'd100, 32'd1, 16'd4, 24'd50);
    wait_go(GAP);
    run_trial(10, 0, wlen);
    wait_go(GAP + 1);
    run_trial(10, 1, wlen);
    wait_go(GAP + 1);
    run_trial(0, 2, wlen);
    check("timeout_wait_len", 32'(wlen), 32'd51);
    wait_go(GAP + 1);
    run_trial(10, 0, wlen);
    finish_sweep(16'd3, 16'd1, 16'd1, 32'd103);

    // NUM=0 gives an immediate DONE. BUSY stays low and the counters are kept.
    start_sweep(32'd5, 32'd5, 16'd0, 24'd10);
    check("num0_done", 32'(DONE), 32'd1);
    check("num0_idx", 32'(TRIAL_IDX), 32'd3);
    check("num0_fail", 32'(FAIL_COUNT), 32'd1);
    check("num0_tmo", 32'(TIMEOUT_COUNT), 32'd1);
    check("num0_cyc", mbus.GLITCH_CYCLES, 32'd103);
    flag = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (BUSY || DONE) flag = 1;
    end
    check("num0_quiet", 32'(flag), 32'd0);

    // A verdict that lands on the timeout cycle wins.
    start_sweep(32'd1, 32'd1, 16'd1, 24'd30);
    wait_go(GAP);
    run_trial(32, 1, wlen);
    check("simul_wait_len", 32'(wlen), 32'd31);
    finish_sweep(16'd0, 16'd1, 16'd0, 32'd1);

    // ABORT in WAIT of trial 1. It beats both the verdict and START.
    start_sweep(32'd7, 32'd2, 16'd5, 24'd100);
    wait_go(GAP);
    run_trial(5, 1, wlen);
    wait_go(GAP + 1);
    tick();
    tick();
    ABORT = 1'b1;
    START = 1'b1;
    mbus.TRIAL_RESULT_VALID = 1'b1;
    mbus.TRIAL_RESULT_FAIL  = 1'b1;
    tick();
    ABORT = 1'b0;
    START = 1'b0;
    mbus.TRIAL_RESULT_VALID = 1'b0;
    mbus.TRIAL_RESULT_FAIL  = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_en", 32'(mbus.GLITCH_ENABLE), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_idx", 32'(TRIAL_IDX), 32'd1);
    check("abort_fail", 32'(FAIL_COUNT), 32'd1);
    check("abort_cyc", mbus.GLITCH_CYCLES, 32'd9);
    tick();
    check("abort_no_done", 32'(DONE), 32'd0);
    check("abort_stays_idle", 32'(BUSY), 32'd0);
    $display("abort idx=%0d fails=%0d width=0x%08h", TRIAL_IDX, FAIL_COUNT, mbus.GLITCH_CYCLES);
    exp_q.delete();
    start_sweep(32'd7, 32'd2, 16'd2, 24'd100);
    check("restart_idx", 32'(TRIAL_IDX), 32'd0);
    check("restart_fail", 32'(FAIL_COUNT), 32'd0);
    check("restart_cyc", mbus.GLITCH_CYCLES, 32'd7);
    wait_go(GAP);
    run_trial(5, 0, wlen);
    wait_go(GAP + 1);
    run_trial(5, 0, wlen);
    finish_sweep(16'd1, 16'd0, 16'd0, 32'd9);

    // Width wraps silently. A START while BUSY, with a new config, is ignored.
    start_sweep(32'hFFFF_FFFE, 32'd3, 16'd2, 24'd100);
    CFG_FIRST = 32'd0;
    CFG_STEP  = 32'd100;
    CFG_NUM   = 16'd9;
    START     = 1'b1;
    tick();
    START = 1'b0;
    check("busy_start_ignored", 32'(BUSY), 32'd1);
    wait_go(GAP - 1);
    run_trial(5, 0, wlen);
    wait_go(GAP + 1);
    check("wrap_width", mbus.GLITCH_CYCLES, 32'h0000_0001);
    run_trial(5, 0, wlen);
    finish_sweep(16'd1, 16'd0, 16'd0, 32'h0000_0001);

    // Reset in the GAP of trial 1.
    start_sweep(32'd50, 32'd1, 16'd3, 24'd100);
    wait_go(GAP);
    run_trial(5, 1, wlen);
    tick();
    check("pre_reset_busy", 32'(BUSY), 32'd1);
    check("pre_reset_idx", 32'(TRIAL_IDX), 32'd1);
    RESETn = 1'b0;
    tick();
    check_all_zero("midreset");
    RESETn = 1'b1;
    flag = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (BUSY || mbus.GLITCH_ENABLE || mbus.TRIAL_GO || DONE) flag = 1;
    end
    check("post_reset_idle", 32'(flag), 32'd0);
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mbus_glitch_sweep.md
# mbus_glitch_sweep

Sequencer that drives an MBus glitch injector through a sweep of glitch widths for regression testing. For each trial it re-arms the injector by pulsing its `ENABLE` low, then high. It presents the current width on `GLITCH_CYCLES` and launches a bus transaction from the test harness. It then waits for the harness pass/fail verdict, or for a timeout. It sits between the host/test-control registers and the glitch injector's `ENABLE`/`GLITCH_CYCLES` inputs, and accumulates failure and timeout statistics.

## Interface
- `IDLE_GAP`, default 16: cycles `GLITCH_ENABLE` is held low before each trial; legal range 1..65535.
- `SYSCLK` in 1: system clock; all logic on rising edge.
- `RESETn` in 1: synchronous, active-low reset.
- `START` in 1: one-cycle pulse that begins a sweep; honoured only in IDLE.
- `ABORT` in 1: stops the sweep, returns to IDLE next cycle.
- `CFG_FIRST` in 32: glitch width of trial 0, in SYSCLK cycles.
- `CFG_STEP` in 32: width increment per trial.
- `CFG_NUM` in 16: number of trials.
- `CFG_TIMEOUT` in 24: WAIT-state cycle limit per trial.
- `TRIAL_RESULT_VALID` in 1: harness verdict strobe.
- `TRIAL_RESULT_FAIL` in 1: verdict; 1 means the transaction failed. Qualified by `TRIAL_RESULT_VALID`.
- `GLITCH_ENABLE` out 1: drives the injector's `ENABLE`.
- `GLITCH_CYCLES` out 32: drives the injector's `GLITCH_CYCLES`.
- `TRIAL_GO` out 1: one-cycle pulse telling the harness to launch a transaction.
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse on normal sweep completion.
- `TRIAL_IDX` out 16: index of the current or most recent trial.
- `FAIL_COUNT` out 16: number of failing verdicts.
- `TIMEOUT_COUNT` out 16: number of trials that timed out.

## Operation
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- Configuration inputs are latched on the accepted `START`. Later changes have no effect on a running sweep.
- **IDLE**
  - `GLITCH_ENABLE` is 0.
  - `START` with `CFG_NUM` = 0: pulse `DONE`, stay in IDLE, leave the counters untouched.
  - `START` with `CFG_NUM` != 0:
    - Latch the configuration.
    - Set `GLITCH_CYCLES` = `CFG_FIRST`.
    - Clear `TRIAL_IDX`, `FAIL_COUNT` and `TIMEOUT_COUNT`.
    - Go to GAP.
- **GAP**
  - `GLITCH_ENABLE` is 0.
  - The gap counter loads `IDLE_GAP`-1 on entry and counts down.
  - When the counter reaches 0, go to ARM.
- **ARM** (one cycle)
  - `GLITCH_ENABLE` is 1 and `TRIAL_GO` is 1.
  - The timeout counter is cleared.
  - Go to WAIT.
- **WAIT**
  - `GLITCH_ENABLE` is 1 and the timeout counter increments each cycle.
  - On `TRIAL_RESULT_VALID`: if `TRIAL_RESULT_FAIL` is 1, increment `FAIL_COUNT`. Go to NEXT.
  - Otherwise, when the counter equals `CFG_TIMEOUT`: increment `TIMEOUT_COUNT` and go to NEXT.
  - If the verdict and the timeout land in the same cycle, the verdict wins and `TIMEOUT_COUNT` is unchanged.
  - `CFG_TIMEOUT` = 0 times out on the first WAIT cycle unless a verdict is present in that cycle.
- **NEXT** (one cycle)
  - `GLITCH_ENABLE` is 0.
  - If `TRIAL_IDX` = latched NUM-1: pulse `DONE` and go to IDLE. `TRIAL_IDX` and `GLITCH_CYCLES` hold their last values.
  - Otherwise: `TRIAL_IDX` += 1, `GLITCH_CYCLES` += STEP (modulo 2^32, wrap silent), go to GAP.
- **Ignored inputs**
  - `TRIAL_RESULT_VALID` outside WAIT is ignored.
  - `START` while `BUSY` is ignored.
- **ABORT**
  - Takes effect from any state, and has priority over `START` and over the verdict.
  - Next cycle: IDLE, `GLITCH_ENABLE` = 0, no `DONE` pulse.
  - Counters and `GLITCH_CYCLES` keep their current values.
- Reset mid-sweep behaves like ABORT, except that every output returns to 0.

## Timing
- `START` is sampled at edge 0, which enters GAP. `GLITCH_ENABLE` is low for `IDLE_GAP` cycles, then ARM.
- ARM to ARM is `IDLE_GAP` + 2 + W cycles, where W is the number of WAIT cycles (≥ 1).
- `GLITCH_ENABLE` low time between trials is `IDLE_GAP` + 1 cycles (NEXT plus GAP). This guarantees the injector resets its state and reloads its timer.
- `GLITCH_CYCLES` is stable from GAP entry through NEXT of each trial; it changes only at the NEXT→GAP edge.
- `DONE` is asserted in the same cycle that `BUSY` falls.
- Counter updates are visible the cycle after the WAIT exit edge.

## Test plan
- **Basic sweep.** `IDLE_GAP`=4, FIRST=10, STEP=5, NUM=3, TIMEOUT=100; harness answers pass 20 cycles after each `TRIAL_GO`.
  - Three `TRIAL_GO` pulses, with `GLITCH_CYCLES` 10, 15, 20 in turn.
  - FAIL=0, TIMEOUT=0, `TRIAL_IDX`=2, `DONE` once.
  - `GLITCH_ENABLE` low exactly 5 cycles between trials.
- **Fail/timeout mix.** NUM=4; trial 1 answers fail, trial 2 never answers, TIMEOUT=50.
  - FAIL_COUNT=1, TIMEOUT_COUNT=1.
  - Trial 2 WAIT lasts 51 cycles.
- **Simultaneous verdict and timeout.** Verdict (fail) arrives exactly on the timeout cycle.
  - FAIL_COUNT=1, TIMEOUT_COUNT=0.
- **ABORT.** ABORT during WAIT of trial 1, NUM=5.
  - IDLE next cycle, `GLITCH_ENABLE`=0, no `DONE`, `TRIAL_IDX`=1.
  - A later `START` clears the counters and restarts from FIRST.
- **Boundaries.**
  - NUM=0: `DONE` pulse, `BUSY` never rises.
  - FIRST=0xFFFFFFFE, STEP=3, NUM=2: second width is 0x00000001.
  - `START` pulsed while `BUSY`: ignored.
- **Reset mid-sweep.** `RESETn` low during GAP.
  - All outputs 0 next cycle; state IDLE.
